// File: rtl/ram_port_master_pkg.sv
// Shared types for the RAM port initiator: access sizes and response entries.
// Misalignment checking is enabled by RAM_PORT_MASTER_MISALIGN_CHECK_EN.
package ram_port_master_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } mem_rsp_t;

    // Size code 3 is reserved and behaves as a word access.
    function automatic mem_size_t norm_size(input logic [1:0] sz);
        return (sz == 2'd3) ? WORD : mem_size_t'(sz);
    endfunction

endpackage

// File: rtl/ram_port_master_rsp_fifo.sv
// In-order response buffer of mem_rsp_t entries with occupancy count.
// Depth must be a power of 2 so the pointers wrap naturally.
module rsp_fifo
    import ram_port_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  mem_rsp_t                   push_data,
    input  logic                       pop,
    output mem_rsp_t                   head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    mem_rsp_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ram_port_master.sv
// Load/store initiator for one port of the byte-enable block RAM.
// Build option: RAM_PORT_MASTER_MISALIGN_CHECK_EN rejects misaligned accesses.
module ram_port_master
    import ram_port_master_pkg::*;
#(
    parameter int LINES     = 8192,
    parameter int RSP_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic                      req_we,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_data,
    output logic                      rsp_err,
    output logic [$clog2(LINES)-1:0]  ram_addr,
    output logic                      ram_en,
    output logic [3:0]                ram_be,
    output logic [31:0]               ram_data_in,
    input  logic [31:0]               ram_data_out
);

    localparam int AW = $clog2(LINES);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    function automatic logic [3:0] be_gen(input mem_size_t sz,
                                          input logic [1:0] off);
        unique case (sz)
            BYTE:    return 4'b0001 << off;
            HALF:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] align(input mem_size_t sz,
                                          input logic [31:0] d);
        unique case (sz)
            BYTE:    return {4{d[7:0]}};
            HALF:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] d,
                                            input mem_size_t sz,
                                            input logic [1:0] off,
                                            input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*off +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        unique case (sz)
            BYTE:    return {{24{~uns & b[7]}}, b};
            HALF:    return {{16{~uns & h[15]}}, h};
            default: return d;
        endcase
    endfunction

    mem_size_t       size;
    logic            err;
    logic            accept;
    logic            unused_addr;

    // One response stage: a load waiting for RAM data, or a store/error reply.
    logic            stg_valid;
    logic            stg_load;
    logic [1:0]      stg_off;
    mem_size_t       stg_size;
    logic            stg_uns;
    logic            stg_err;

    mem_rsp_t        push_data;
    mem_rsp_t        head;
    logic [CW-1:0]   count;
    logic [CW-1:0]   used;
    logic            pop;

    assign size = norm_size(req_size);

`ifdef RAM_PORT_MASTER_MISALIGN_CHECK_EN
    assign err = ((size == HALF) && req_addr[0]) ||
                 ((size == WORD) && (req_addr[1:0] != 2'b00));
`else
    assign err = 1'b0;
`endif

    assign used      = count + CW'(stg_valid);
    assign req_ready = ~rst & (used < CW'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;

    assign ram_en      = accept & ~err;
    assign ram_addr    = req_addr[AW+1:2];
    assign ram_be      = (ram_en && req_we) ? be_gen(size, req_addr[1:0])
                                            : 4'b0000;
    assign ram_data_in = align(size, req_wdata);
    assign unused_addr = ^req_addr[31:AW+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= 1'b0;
            stg_load  <= 1'b0;
            stg_off   <= 2'b00;
            stg_size  <= BYTE;
            stg_uns   <= 1'b0;
            stg_err   <= 1'b0;
        end else begin
            stg_valid <= accept;
            stg_load  <= accept & ~req_we & ~err;
            stg_off   <= req_addr[1:0];
            stg_size  <= size;
            stg_uns   <= req_unsigned;
            stg_err   <= accept & err;
        end
    end

    always_comb begin
        push_data.data = '0;
        push_data.err  = stg_err;
        if (stg_load) begin
            push_data.data = extract(ram_data_out, stg_size, stg_off, stg_uns);
        end
    end

    assign pop = rsp_valid & rsp_ready;

    rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stg_valid),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign rsp_valid = (count != '0);
    assign rsp_data  = rsp_valid ? head.data : 32'h0;
    assign rsp_err   = rsp_valid & head.err;

endmodule

// File: tb/tb_ram_port_master.sv
// Directed scoreboard bench for ram_port_master with a behavioural RAM.
// Honours RAM_PORT_MASTER_MISALIGN_CHECK_EN for the misaligned-load case.
module tb_ram_port_master;

    localparam int LINES = 64;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(LINES);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic [AW-1:0] ram_addr;
    logic          ram_en;
    logic [3:0]    ram_be;
    logic [31:0]   ram_data_in;
    logic [31:0]   ram_data_out = '0;

    int checks = 0;
    int errors = 0;

    logic [32:0]  exp_q [$];
    logic [31:0]  mem [LINES];
    logic         last_en;
    logic [3:0]   last_be;
    logic [31:0]  last_din;

    always #5 clk = ~clk;

    ram_port_master #(
        .LINES     (LINES),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .ram_addr     (ram_addr),
        .ram_en       (ram_en),
        .ram_be       (ram_be),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_be == 4'b0000) begin
                ram_data_out <= mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got %h with empty scoreboard", rsp_data);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e[32:1]);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e[0]});
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic we,
                         input logic [1:0] sz, input logic un,
                         input logic [31:0] wd, input logic [31:0] ed,
                         input logic ee, input logic sb);
        int n;
        req_addr = a;
        req_we = we;
        req_size = sz;
        req_unsigned = un;
        req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        #1;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: req_ready 0 expected 1");
        end
        last_en = ram_en;
        last_be = ram_be;
        last_din = ram_data_in;
        if (sb) exp_q.push_back({ed, ee});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] v_addr [4] = '{32'h10, 32'h00, 32'h04, 32'h13};
    logic [1:0]  v_size [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
    logic [31:0] v_exp  [4] = '{32'h8001_7FFF, 32'h1234_5678,
                                32'hABCD_0000, 32'h0000_0080};

    initial begin
        int acc;
        for (int i = 0; i < LINES; i++) mem[i] = '0;
        #1;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 0);
        chk("rst_req_ready", {31'b0, req_ready}, 0);
        chk("rst_ram_en", {31'b0, ram_en}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        issue(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
        chk("word_st_be", {28'b0, last_be}, 32'hF);
        chk("word_st_din", last_din, 32'hDEAD_BEEF);
        issue(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("word_ld_en", {31'b0, last_en}, 1);
        chk("word_ld_be", {28'b0, last_be}, 0);
        @(posedge clk);
        #1;
        chk("ld_latency_valid", {31'b0, rsp_valid}, 1);
        chk("ld_latency_data", rsp_data, 32'hDEAD_BEEF);
        drain();

        issue(32'h13, 1'b1, 2'd0, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 1'b1);
        chk("byte_st_be", {28'b0, last_be}, 32'h8);
        chk("byte_st_din", last_din, 32'h8080_8080);
        issue(32'h13, 1'b0, 2'd0, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1);
        issue(32'h13, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0000_0080, 1'b0, 1'b1);
        issue(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 32'h80AD_BEEF, 1'b0, 1'b1);
        drain();

        issue(32'h10, 1'b1, 2'd3, 1'b0, 32'h8001_7FFF, 32'h0, 1'b0, 1'b1);
        chk("rsvd_st_be", {28'b0, last_be}, 32'hF);
        issue(32'h12, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0, 1'b1);
        issue(32'h12, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0000_8001, 1'b0, 1'b1);
        issue(32'h10, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0000_7FFF, 1'b0, 1'b1);
        issue(32'h10, 1'b0, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();

        issue(32'h00, 1'b1, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        issue(32'h06, 1'b1, 2'd1, 1'b0, 32'h0000_ABCD, 32'h0, 1'b0, 1'b1);
        chk("half_st_be", {28'b0, last_be}, 32'hC);
        chk("half_st_din", last_din, 32'hABCD_ABCD);
`ifdef RAM_PORT_MASTER_MISALIGN_CHECK_EN
        issue(32'h02, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("misalign_en", {31'b0, last_en}, 0);
`else
        issue(32'h02, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 1'b1);
        chk("misalign_en", {31'b0, last_en}, 1);
`endif
        drain();

        rsp_ready = 1'b0;
        acc = 0;
        req_we = 1'b0;
        req_unsigned = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (acc > 3) ? 3 : acc;
            req_addr = v_addr[k];
            req_size = v_size[k];
            #1;
            if (req_ready) begin
                exp_q.push_back({v_exp[k], 1'b0});
                acc++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", acc, DEPTH);
        chk("b2b_ready_low", {31'b0, req_ready}, 0);
        chk("b2b_held", {31'b0, rsp_valid}, 1);
        rsp_ready = 1'b1;
        drain();

        issue(32'h00, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'b0, req_ready}, 0);
        chk("mid_rst_valid", {31'b0, rsp_valid}, 0);
        req_valid = 1'b1;
        #1;
        chk("mid_rst_en", {31'b0, ram_en}, 0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid2", {31'b0, rsp_valid}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", {31'b0, rsp_valid}, 0);
        issue(32'h00, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
